// File: rtl/spi_rdid_responder_if.sv
// SPI pad-side bus between an RDID master and the flash-side responder.
interface spi_rdid_responder_if;
    logic sck;
    logic cs_n;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output sck, output cs_n, output mosi, input miso, input miso_oe);
    modport slave  (input sck, input cs_n, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_rdid_responder.sv
// SPI mode-0 flash stand-in: answers the RDID command with a repeating 3-byte JEDEC ID.
// SCK, CS_N and MOSI are oversampled in the clk domain.
module spi_rdid_responder #(
    parameter logic [7:0]  CMD_RDID = 8'h9F,
    parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
    input  logic                        clk,
    input  logic                        reset,
    spi_rdid_responder_if.slave         bus,
    output logic [7:0]                  cmd_byte,
    output logic                        cmd_strobe,
    output logic                        busy
);
    typedef enum logic [1:0] {IDLE, CMD, ID_OUT, IGNORE} state_t;

    state_t      state, state_next;
    logic        sck_s1, sck_s2, sck_s3;
    logic        cs_s1, cs_s2;
    logic        mosi_s1, mosi_s2;
    logic        sck_rise, sck_fall, cs_active;
    logic [7:0]  shift_reg, shift_next;
    logic [2:0]  bit_cnt;
    logic [1:0]  byte_idx;
    logic [2:0]  bit_idx;
    logic [4:0]  id_base, id_pos;
    logic        cmd_done;

    // Synchronizers reset to the idle bus levels so reset release never fakes an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_s3  <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sck_s1  <= bus.sck;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            cs_s1   <= bus.cs_n;
            cs_s2   <= cs_s1;
            mosi_s1 <= bus.mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    assign sck_rise  = sck_s2 & ~sck_s3;
    assign sck_fall  = ~sck_s2 & sck_s3;
    assign cs_active = ~cs_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!cs_active) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_next = CMD;
                CMD:     if (cmd_done) state_next = (shift_next == CMD_RDID) ? ID_OUT : IGNORE;
                ID_OUT:  state_next = ID_OUT;
                IGNORE:  state_next = IGNORE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state != IDLE);
        shift_next = {shift_reg[6:0], mosi_s2};
        cmd_done   = (state == CMD) && sck_rise && (bit_cnt == 3'd7);
        unique case (byte_idx)
            2'd0:    id_base = 5'd16;
            2'd1:    id_base = 5'd8;
            default: id_base = 5'd0;
        endcase
        id_pos = id_base + {2'b00, bit_idx};
    end

    // CS deassert is checked first so it wins over a coincident SCK edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            byte_idx   <= '0;
            bit_idx    <= 3'd7;
            cmd_byte   <= '0;
            cmd_strobe <= 1'b0;
            bus.miso    <= 1'b0;
            bus.miso_oe <= 1'b0;
        end else begin
            cmd_strobe <= 1'b0;
            if (!cs_active || state == IDLE) begin
                shift_reg   <= '0;
                bit_cnt     <= '0;
                byte_idx    <= '0;
                bit_idx     <= 3'd7;
                bus.miso    <= 1'b0;
                bus.miso_oe <= 1'b0;
            end else if (state == CMD) begin
                if (sck_rise) begin
                    shift_reg <= shift_next;
                    bit_cnt   <= bit_cnt + 3'd1;
                end
                if (cmd_done) begin
                    cmd_byte   <= shift_next;
                    cmd_strobe <= 1'b1;
                    byte_idx   <= '0;
                    bit_idx    <= 3'd7;
                end
            end else if (state == ID_OUT) begin
                if (sck_fall) begin
                    bus.miso    <= JEDEC_ID[id_pos];
                    bus.miso_oe <= 1'b1;
                end else if (sck_rise) begin
                    if (bit_idx == 3'd0) begin
                        bit_idx  <= 3'd7;
                        byte_idx <= (byte_idx == 2'd2) ? 2'd0 : byte_idx + 2'd1;
                    end else begin
                        bit_idx <= bit_idx - 3'd1;
                    end
                end
            end else begin
                bus.miso    <= 1'b0;
                bus.miso_oe <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_rdid_responder.sv
// Scoreboard bench for spi_rdid_responder: a master task drives SPI traffic and queues
// expected command bytes and ID bits; independent monitors pop and compare.
`timescale 1ns/1ps
module tb_spi_rdid_responder;
    localparam logic [7:0]  CMD_RDID = 8'h9F;
    localparam logic [23:0] JID      = 24'hEF4018;
    localparam int unsigned HALF     = 5;   // 50 MHz clk, 5 MHz SCK

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cmd_byte;
    logic       cmd_strobe;
    logic       busy;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        id_phase = 1'b0;
    logic [7:0]  exp_cmd[$];
    logic        exp_bit[$];

    spi_rdid_responder_if bus ();

    spi_rdid_responder #(.CMD_RDID(CMD_RDID), .JEDEC_ID(JID)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .bus        (bus),
        .cmd_byte   (cmd_byte),
        .cmd_strobe (cmd_strobe),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the ID stream is the 24-bit value MSB first, repeating.
    function automatic logic model_bit(input int unsigned k);
        logic [23:0] id;
        id = JID;
        return id[5'(23 - (k % 24))];
    endfunction

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sck_cycle();
        wait_clk(HALF);
        bus.sck = 1'b1;
        wait_clk(HALF);
        bus.sck = 1'b0;
    endtask

    task automatic spi_xfer(input logic [7:0] cmd, input int unsigned cmd_bits, input int unsigned id_clks);
        bus.cs_n = 1'b0;
        wait_clk(5);
        for (int unsigned i = 0; i < cmd_bits; i++) begin
            bus.mosi = cmd[3'(7 - i)];
            if (i == 7) exp_cmd.push_back(cmd);
            sck_cycle();
        end
        if (cmd_bits == 8) begin
            id_phase = (cmd == CMD_RDID);
            for (int unsigned k = 0; k < id_clks; k++) begin
                bus.mosi = 1'($urandom_range(0, 1));
                if (id_phase) exp_bit.push_back(model_bit(k));
                sck_cycle();
            end
        end
        wait_clk(HALF);
        bus.cs_n = 1'b1;
        id_phase = 1'b0;
        wait_clk(4);
        check("busy_after_cs", 32'(busy), 32'd0);
        check("oe_after_cs", 32'(bus.miso_oe), 32'd0);
        wait_clk(4);
    endtask

    // Master-side sampling of MISO on each SCK rise.
    always @(posedge bus.sck) begin
        if (id_phase) begin
            check("oe_in_id", 32'(bus.miso_oe), 32'd1);
            if (exp_bit.size() == 0) begin
                check("id_queue_empty", 32'd1, 32'd0);
            end else begin
                check("miso_bit", 32'(bus.miso), 32'(exp_bit.pop_front()));
            end
        end else begin
            check("oe_outside_id", 32'(bus.miso_oe), 32'd0);
        end
        check("busy_in_xfer", 32'(busy), 32'd1);
    end

    always @(negedge clk) begin
        if (cmd_strobe) begin
            if (exp_cmd.size() == 0) begin
                check("unexpected_strobe", 32'(cmd_byte), 32'hFFFF_FFFF);
            end else begin
                check("cmd_byte", 32'(cmd_byte), 32'(exp_cmd.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rc;
        int unsigned rb;
        bus.sck  = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
        check("rst_miso", 32'(bus.miso), 32'd0);
        check("rst_oe", 32'(bus.miso_oe), 32'd0);
        check("rst_cmd_byte", 32'(cmd_byte), 32'd0);
        check("rst_strobe", 32'(cmd_strobe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        spi_xfer(8'h9F, 8, 24);
        spi_xfer(8'h9F, 8, 48);
        spi_xfer(8'h05, 8, 16);
        check("cmd_byte_hold", 32'(cmd_byte), 32'h05);
        spi_xfer(8'h9F, 5, 0);
        check("cmd_byte_after_abort", 32'(cmd_byte), 32'h05);
        spi_xfer(8'h9F, 8, 24);
        spi_xfer(8'h9F, 8, 10);

        // Reset in the middle of ID output.
        bus.cs_n = 1'b0;
        wait_clk(5);
        for (int unsigned i = 0; i < 8; i++) begin
            bus.mosi = CMD_RDID[3'(7 - i)];
            if (i == 7) exp_cmd.push_back(CMD_RDID);
            sck_cycle();
        end
        id_phase = 1'b1;
        for (int unsigned k = 0; k < 5; k++) begin
            exp_bit.push_back(model_bit(k));
            sck_cycle();
        end
        wait_clk(2);
        rst_n = 1'b0;
        id_phase = 1'b0;
        #1;
        check("midrst_miso", 32'(bus.miso), 32'd0);
        check("midrst_oe", 32'(bus.miso_oe), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cmd_byte", 32'(cmd_byte), 32'd0);
        wait_clk(3);
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(4);
        spi_xfer(8'h9F, 8, 24);

        for (int unsigned t = 0; t < 16; t++) begin
            rc = ($urandom_range(0, 1) == 1) ? CMD_RDID : 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
            spi_xfer(rc, rb, $urandom_range(0, 50));
        end

        wait_clk(10);
        check("cmd_queue_drained", 32'(exp_cmd.size()), 32'd0);
        check("bit_queue_drained", 32'(exp_bit.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_rdid_responder.md
# spi_rdid_responder

SPI-mode-0 slave that acts as the flash-side partner of the RDID (0x9F) instruction initiator. It receives a command byte on MOSI and, when the byte matches RDID, returns the 3-byte JEDEC ID on MISO, MSB first. It oversamples SCK, CS_N and MOSI in the system clock domain. It is used as a synthesizable flash stand-in for board bring-up and as the bench partner for the initiator and the debounced-button trigger path.

## Interface
- `CMD_RDID`, default 8'h9F: command byte that selects the ID response.
- `JEDEC_ID`, default 24'hEF4018: ID returned as manufacturer, memory type, capacity, in that order.
- `clk` input, 1 bit: system clock; all logic sits on its rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `sck` input, 1 bit: SPI clock, asynchronous to `clk`.
- `cs_n` input, 1 bit: SPI chip select, active-low, asynchronous to `clk`.
- `mosi` input, 1 bit: SPI data in, asynchronous to `clk`.
- `miso` output, 1 bit: SPI data out.
- `miso_oe` output, 1 bit: output enable for the MISO pad driver; high only while ID bits are being shifted.
- `cmd_byte` output, 8 bits: last complete command byte received.
- `cmd_strobe` output, 1 bit: one-`clk` pulse each time a command byte completes.
- `busy` output, 1 bit: high whenever the FSM is not in IDLE.

## Operation
- **Input synchronizers**: `sck`, `cs_n` and `mosi` each pass through a 2-FF synchronizer.
- **Edge detect**: a third register on SCK gives `sck_rise` and `sck_fall` pulses. `cs_active` is the synchronized `cs_n` inverted.
- **FSM states**:
  - IDLE: `miso_oe`=0, bit counter=0. Enter CMD when `cs_active` is detected.
  - CMD: on each `sck_rise`, shift the synchronized MOSI into an 8-bit shift register, MSB first, and increment the 3-bit bit counter.
    - After the 8th rise: load `cmd_byte`, pulse `cmd_strobe`.
    - If the byte equals `CMD_RDID`, go to ID_OUT with byte index 0 and bit index 7. Otherwise go to IGNORE.
  - ID_OUT:
    - On each `sck_fall`: drive `miso` = `JEDEC_ID[23 - 8*byte_idx - (7 - bit_idx)]` and set `miso_oe`=1.
    - On each `sck_rise` after that bit: decrement `bit_idx`.
    - At bit 0 of byte 2: wrap to byte 0, bit 7, so the ID repeats while CS stays low (this matches real flash behaviour).
    - MOSI is ignored.
  - IGNORE: `miso`=0, `miso_oe`=0, MOSI is ignored until CS deasserts.
- **CS deassert**: synchronized `cs_n` high in any state returns the FSM to IDLE on the next `clk`. The shift register, bit counter and indices clear, and `miso_oe` drops. A partial command byte is discarded with no `cmd_strobe`.
- **CS re-assert**: a CS low after a deassert starts a fresh transaction; no state carries over except `cmd_byte`.
- **Simultaneous events**: if CS deassert and an SCK edge are detected in the same `clk`, CS deassert wins.
- **Reset values**: `miso`=0, `miso_oe`=0, `cmd_byte`=8'h00, `cmd_strobe`=0, `busy`=0. All synchronizer flops reset to the idle bus levels: `sck`=0, `cs_n`=1, `mosi`=0.
- **Reset mid-transfer**: reset forces IDLE immediately, regardless of bus activity.

## Timing
- Input-to-detect latency: 3 `clk` cycles from a pin edge to the `sck_rise`/`sck_fall` pulse.
- SCK limits: SCK frequency ≤ `clk`/8, and SCK high and low times are each ≥ 4 `clk` periods.
- CS setup: CS low ≥ 4 `clk` before the first SCK rise.
- MISO output delay: `miso` changes 4 `clk` after the physical SCK falling edge. That is within half an SCK period, so the master samples stable data on the next rise.
- First ID bit: driven on the SCK fall that follows the 8th command rise, i.e. the fall ending bit 7 of the command.
- `cmd_strobe`: asserted in the `clk` after the 8th `sck_rise` pulse, for exactly 1 cycle.
- Full RDID transaction: 32 SCK cycles (8 command bits, then 24 ID bits).

## Test plan
- **Reset**: assert `reset`=0 with the bus idle, then release → all outputs at their reset values, `busy`=0.
- **RDID read**: `clk` 50 MHz, SCK 5 MHz, CS low, shift 8'h9F then 24 clocks → `cmd_strobe` once, `cmd_byte`=8'h9F, master samples 24'hEF4018, `miso_oe` high only during the ID bits.
- **ID wrap**: as the RDID read, but 48 ID clocks → master reads 24'hEF4018 twice.
- **Non-matching command**: shift 8'h05 → `cmd_byte`=8'h05, `cmd_strobe` pulses, `miso_oe` stays 0, `busy` stays 1 until CS rises.
- **Abort mid-command**: CS rises after 5 command bits, then a full 8'h9F transaction follows → no `cmd_strobe` from the aborted byte, and the second transaction returns 24'hEF4018.
- **Abort mid-ID**: CS rises after 10 ID bits → `miso_oe`=0 and `busy`=0 within 4 `clk`. Then assert `reset` low during a later transfer → outputs reset immediately, and the next full transaction works.
